// File: rtl/rgb_hue_pwm_if.sv
// Control/status bundle between top-level logic and the RGB hue PWM driver.
`timescale 1ns/1ps
interface rgb_hue_pwm_if #(
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned SEG_STEPS = 60,
  parameter int unsigned DIV_BITS  = 24
);
  localparam int unsigned HUE_W = $clog2(6 * SEG_STEPS);

  logic                en;
  logic [1:0]          mode;
  logic [DIV_BITS-1:0] step_div;
  logic [PWM_BITS-1:0] bright;
  logic                hue_load;
  logic [HUE_W-1:0]    hue_in;
  logic                RGB_R;
  logic                RGB_G;
  logic                RGB_B;
  logic [HUE_W-1:0]    hue_out;
  logic                frame_tick;

  modport master (
    output en, mode, step_div, bright, hue_load, hue_in,
    input  RGB_R, RGB_G, RGB_B, hue_out, frame_tick
  );

  modport slave (
    input  en, mode, step_div, bright, hue_load, hue_in,
    output RGB_R, RGB_G, RGB_B, hue_out, frame_tick
  );
endinterface

// File: rtl/rgb_hue_pwm.sv
// Hue-wheel PWM driver: walks or holds a hue, scales by brightness and a
// triangular breathe envelope, drives active-low glitch-free PWM per frame.
`timescale 1ns/1ps
module rgb_hue_pwm #(
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned SEG_STEPS = 60,
  parameter int unsigned DIV_BITS  = 24
) (
  input  logic         CLK,
  input  logic         RST_N,
  rgb_hue_pwm_if.slave bus
);
  localparam int unsigned MAX     = (1 << PWM_BITS) - 1;
  localparam int unsigned HUE_MAX = 6 * SEG_STEPS;
  localparam int unsigned HUE_W   = $clog2(HUE_MAX);
  localparam int unsigned PROD_W  = 2 * PWM_BITS;
  localparam int unsigned RAMP_W  = HUE_W + PWM_BITS;

  localparam logic [PWM_BITS-1:0] MAX_V    = PWM_BITS'(MAX);
  localparam logic [PWM_BITS-1:0] LAST_V   = PWM_BITS'(MAX - 1);
  localparam logic [HUE_W-1:0]    HUE_LAST = HUE_W'(HUE_MAX - 1);
  localparam logic [HUE_W-1:0]    SEG_V    = HUE_W'(SEG_STEPS);
  localparam logic [1:0]          MODE_CYCLE   = 2'd0;
  localparam logic [1:0]          MODE_BREATHE = 2'd2;

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [DIV_BITS-1:0] r_div_cnt;
  logic [HUE_W-1:0]    r_hue;
  logic [PWM_BITS-1:0] r_env;
  logic                r_env_dn;
  logic [PWM_BITS-1:0] r_duty_r;
  logic [PWM_BITS-1:0] r_duty_g;
  logic [PWM_BITS-1:0] r_duty_b;
  logic                r_rgb_r;
  logic                r_rgb_g;
  logic                r_rgb_b;
  logic                r_frame_tick;

  logic                w_frame_end;
  logic                w_tick;
  logic [DIV_BITS-1:0] w_div_last;
  logic [2:0]          w_seg;
  logic [HUE_W-1:0]    w_off;
  logic [RAMP_W-1:0]   w_ramp_prod;
  logic [PWM_BITS-1:0] w_ramp;
  logic [PWM_BITS-1:0] w_base_r;
  logic [PWM_BITS-1:0] w_base_g;
  logic [PWM_BITS-1:0] w_base_b;
  logic [PWM_BITS-1:0] w_eff;
  logic [PWM_BITS-1:0] w_duty_r;
  logic [PWM_BITS-1:0] w_duty_g;
  logic [PWM_BITS-1:0] w_duty_b;

  // floor(a*b/MAX); the product never exceeds 2*PWM_BITS bits
  function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] a,
                                                input logic [PWM_BITS-1:0] b);
    logic [PROD_W-1:0] p;
    p = PROD_W'(a) * PROD_W'(b);
    return PWM_BITS'(p / PROD_W'(MAX));
  endfunction

  assign w_frame_end = bus.en & (r_pwm_cnt == LAST_V);

  // step_div of 0 behaves as 1, so the last count is 0 in both cases
  always_comb begin
    w_div_last = '0;
    if (bus.step_div != '0) w_div_last = bus.step_div - DIV_BITS'(1);
  end

  assign w_tick = bus.en & (r_div_cnt >= w_div_last);

  assign w_seg       = 3'(r_hue / SEG_V);
  assign w_off       = r_hue % SEG_V;
  assign w_ramp_prod = RAMP_W'(w_off) * RAMP_W'(MAX);
  assign w_ramp      = PWM_BITS'(w_ramp_prod / RAMP_W'(SEG_STEPS));

  // Six-segment hue wheel base colour
  always_comb begin
    w_base_r = '0;
    w_base_g = '0;
    w_base_b = '0;
    case (w_seg)
      3'd0: begin w_base_r = MAX_V;          w_base_g = w_ramp;         end
      3'd1: begin w_base_r = MAX_V - w_ramp; w_base_g = MAX_V;          end
      3'd2: begin w_base_g = MAX_V;          w_base_b = w_ramp;         end
      3'd3: begin w_base_g = MAX_V - w_ramp; w_base_b = MAX_V;          end
      3'd4: begin w_base_r = w_ramp;         w_base_b = MAX_V;          end
      3'd5: begin w_base_r = MAX_V;          w_base_b = MAX_V - w_ramp; end
      default: ;
    endcase
  end

  assign w_eff    = (bus.mode == MODE_BREATHE) ? scale(bus.bright, r_env) : bus.bright;
  assign w_duty_r = scale(w_base_r, w_eff);
  assign w_duty_g = scale(w_base_g, w_eff);
  assign w_duty_b = scale(w_base_b, w_eff);

  // PWM frame counter and frame tick
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pwm_cnt    <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_end;
      if (!bus.en || w_frame_end) r_pwm_cnt <= '0;
      else                        r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_div_cnt <= '0;
    end else if (!bus.en || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_BITS'(1);
    end
  end

  // A load always beats a same-cycle wheel step
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_hue <= '0;
    end else if (bus.hue_load) begin
      r_hue <= (32'(bus.hue_in) >= HUE_MAX) ? '0 : bus.hue_in;
    end else if (w_tick && bus.mode == MODE_CYCLE) begin
      r_hue <= (r_hue == HUE_LAST) ? '0 : r_hue + HUE_W'(1);
    end
  end

  // Triangular envelope; each endpoint is visited for a single tick
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_env    <= MAX_V;
      r_env_dn <= 1'b1;
    end else if (bus.en) begin
      if (bus.mode != MODE_BREATHE) begin
        r_env    <= MAX_V;
        r_env_dn <= 1'b1;
      end else if (w_tick) begin
        if (r_env_dn) begin
          if (r_env == '0) begin
            r_env    <= PWM_BITS'(1);
            r_env_dn <= 1'b0;
          end else begin
            r_env <= r_env - PWM_BITS'(1);
          end
        end else begin
          if (r_env == MAX_V) begin
            r_env    <= LAST_V;
            r_env_dn <= 1'b1;
          end else begin
            r_env <= r_env + PWM_BITS'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_duty_r <= '0;
      r_duty_g <= '0;
      r_duty_b <= '0;
    end else if (w_frame_end) begin
      r_duty_r <= w_duty_r;
      r_duty_g <= w_duty_g;
      r_duty_b <= w_duty_b;
    end
  end

  // Registered active-low pins; reset forces them dark immediately
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rgb_r <= 1'b1;
      r_rgb_g <= 1'b1;
      r_rgb_b <= 1'b1;
    end else begin
      r_rgb_r <= ~(bus.en & (r_pwm_cnt < r_duty_r));
      r_rgb_g <= ~(bus.en & (r_pwm_cnt < r_duty_g));
      r_rgb_b <= ~(bus.en & (r_pwm_cnt < r_duty_b));
    end
  end

  assign bus.RGB_R      = r_rgb_r;
  assign bus.RGB_G      = r_rgb_g;
  assign bus.RGB_B      = r_rgb_b;
  assign bus.hue_out    = r_hue;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_rgb_hue_pwm.sv
// Bench for rgb_hue_pwm: directed scenarios plus randomized run against a
// behavioural model of hue wheel, envelope and per-frame duty.
`timescale 1ns/1ps
module tb_rgb_hue_pwm;
  localparam int unsigned PWM_BITS  = 4;
  localparam int unsigned SEG_STEPS = 60;
  localparam int unsigned DIV_BITS  = 24;
  localparam int MAX     = 15;
  localparam int HUE_MAX = 360;

  logic CLK   = 1'b0;
  logic RST_N = 1'b1;

  rgb_hue_pwm_if #(.PWM_BITS(PWM_BITS), .SEG_STEPS(SEG_STEPS), .DIV_BITS(DIV_BITS)) bus ();

  rgb_hue_pwm #(.PWM_BITS(PWM_BITS), .SEG_STEPS(SEG_STEPS), .DIV_BITS(DIV_BITS)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Triangle 15,14..0,1..15,14.. indexed by ticks spent breathing
  function automatic int env_of(input int k);
    int p;
    p = k % (2 * MAX);
    return (p <= MAX) ? MAX - p : p - MAX;
  endfunction

  function automatic int duty_of(input int hue, input int env, input int bright,
                                 input int mode, input int ch);
    int seg, ramp, r, g, b, eff, base;
    seg  = hue / SEG_STEPS;
    ramp = (hue % SEG_STEPS) * MAX / SEG_STEPS;
    r = 0; g = 0; b = 0;
    case (seg)
      0: begin r = MAX;        g = ramp;       end
      1: begin r = MAX - ramp; g = MAX;        end
      2: begin g = MAX;        b = ramp;       end
      3: begin g = MAX - ramp; b = MAX;        end
      4: begin r = ramp;       b = MAX;        end
      default: begin r = MAX;  b = MAX - ramp; end
    endcase
    eff  = (mode == 2) ? bright * env / MAX : bright;
    base = (ch == 0) ? r : (ch == 1) ? g : b;
    return base * eff / MAX;
  endfunction

  // Reference model state
  int       m_pwm = 0, m_div = 0, m_hue = 0, m_k = 0;
  int       m_duty [3] = '{0, 0, 0};
  bit [2:0] m_rgb = 3'b111;
  bit       m_ft  = 1'b0;
  int       md_d;
  bit       md_tick, md_fend;

  initial forever begin
    @(posedge CLK or negedge RST_N);
    if (!RST_N) begin
      m_pwm = 0; m_div = 0; m_hue = 0; m_k = 0;
      m_duty = '{0, 0, 0}; m_rgb = 3'b111; m_ft = 1'b0;
    end else begin
      md_d    = (bus.step_div == 0) ? 1 : int'(bus.step_div);
      md_tick = bus.en && (m_div >= md_d - 1);
      md_fend = bus.en && (m_pwm == MAX - 1);
      for (int c = 0; c < 3; c++) m_rgb[2-c] = !(bus.en && (m_pwm < m_duty[c]));
      if (md_fend)
        for (int c = 0; c < 3; c++)
          m_duty[c] = duty_of(m_hue, env_of(m_k), int'(bus.bright), int'(bus.mode), c);
      m_ft  = md_fend;
      m_pwm = bus.en ? (m_pwm + 1) % MAX : 0;
      m_div = (!bus.en || md_tick) ? 0 : m_div + 1;
      if (bus.hue_load) m_hue = (int'(bus.hue_in) >= HUE_MAX) ? 0 : int'(bus.hue_in);
      else if (md_tick && bus.mode == 2'd0) m_hue = (m_hue + 1) % HUE_MAX;
      if (bus.en) m_k = (bus.mode == 2'd2) ? (md_tick ? (m_k + 1) % (2 * MAX) : m_k) : 0;
    end
  end

  // Cycle-by-cycle scoreboard
  initial forever begin
    @(negedge CLK);
    if (chk_on) begin
      check("rgb", {bus.RGB_R, bus.RGB_G, bus.RGB_B}, m_rgb);
      check("hue", bus.hue_out, m_hue);
      check("frame_tick", bus.frame_tick, m_ft);
    end
  end

  task automatic do_load(input int h);
    bus.hue_in   = 9'(h);
    bus.hue_load = 1'b1;
    @(negedge CLK);
    bus.hue_load = 1'b0;
  endtask

  task automatic wait_ftick();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (bus.frame_tick) seen = 1'b1;
    end
    check("frame_tick_wait", seen, 1);
  endtask

  // Count lit cycles over the 15 cycles after a frame_tick sample
  task automatic count_frame(input int chg_at, input logic [3:0] nb,
                             output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (!bus.RGB_R) r++;
      if (!bus.RGB_G) g++;
      if (!bus.RGB_B) b++;
      if (i == chg_at) bus.bright = nb;
    end
  endtask

  int  r, g, b, n, prev, zeros, fulls, bad_step, gb_sum;
  bit  found;
  int  rc [30];

  initial begin
    bus.en = 1'b1; bus.mode = 2'd1; bus.step_div = 24'd3; bus.bright = 4'd15;
    bus.hue_load = 1'b0; bus.hue_in = '0;
    #2 RST_N = 1'b0;
    #1;
    check("reset_rgb", {bus.RGB_R, bus.RGB_G, bus.RGB_B}, 3'b111);
    check("reset_hue", bus.hue_out, 0);
    check("reset_ftick", bus.frame_tick, 0);
    repeat (3) @(negedge CLK);
    RST_N  = 1'b1;
    chk_on = 1'b1;

    // Async reset mid-run, then first frame_tick latency
    bus.mode = 2'd0; bus.step_div = 24'd3;
    repeat (40) @(negedge CLK);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("async_rgb", {bus.RGB_R, bus.RGB_G, bus.RGB_B}, 3'b111);
    check("async_hue", bus.hue_out, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    found = 1'b0; n = 0;
    for (int i = 1; i <= 40 && !found; i++) begin
      @(negedge CLK);
      if (bus.frame_tick) begin found = 1'b1; n = i; end
    end
    check("first_ftick_clocks", n, 15);

    // Held hue 90 at full brightness
    bus.mode = 2'd1; bus.bright = 4'd15;
    do_load(90);
    wait_ftick();
    count_frame(-1, 4'd0, r, g, b);
    check("h90_r", r, 8);
    check("h90_g", g, 15);
    check("h90_b", b, 0);
    check("h90_hue", bus.hue_out, 90);

    // Brightness change mid-frame only lands at the next boundary
    bus.bright = 4'd7;
    do_load(0);
    wait_ftick();
    count_frame(-1, 4'd0, r, g, b);
    check("b7_r", r, 7);
    check("b7_g", g, 0);
    check("b7_b", b, 0);
    count_frame(4, 4'd15, r, g, b);
    check("b7_midchg_r", r, 7);
    count_frame(-1, 4'd0, r, g, b);
    check("b15_next_r", r, 15);

    // Wrap of the wheel with step_div 0
    bus.mode = 2'd0; bus.step_div = 24'd0;
    bus.hue_in = 9'd358; bus.hue_load = 1'b1;
    @(negedge CLK);
    bus.hue_load = 1'b0;
    check("wrap_0", bus.hue_out, 358);
    @(negedge CLK); check("wrap_1", bus.hue_out, 359);
    @(negedge CLK); check("wrap_2", bus.hue_out, 0);
    @(negedge CLK); check("wrap_3", bus.hue_out, 1);

    // Breathe with one envelope step per frame
    bus.mode = 2'd1; bus.step_div = 24'd15; bus.bright = 4'd15;
    do_load(0);
    repeat (20) @(negedge CLK);
    bus.mode = 2'd2;
    wait_ftick();
    gb_sum = 0;
    for (int f = 0; f < 30; f++) begin
      count_frame(-1, 4'd0, r, g, b);
      rc[f] = r;
      gb_sum += g + b;
    end
    zeros = 0; fulls = 0; bad_step = 0; prev = rc[0];
    for (int f = 0; f < 30; f++) begin
      if (rc[f] == 0)  zeros++;
      if (rc[f] == 15) fulls++;
      if (f > 0 && rc[f] - prev != 1 && prev - rc[f] != 1) bad_step++;
      prev = rc[f];
    end
    check("breathe_zero_frames", zeros, 1);
    check("breathe_full_frames", fulls, 1);
    check("breathe_bad_steps", bad_step, 0);
    check("breathe_gb_lit", gb_sum, 0);
    bus.step_div = 24'd2;
    repeat (150) @(negedge CLK);

    // Out-of-range load on a tick cycle, then en low
    bus.mode = 2'd0; bus.step_div = 24'd0;
    bus.hue_in = 9'd400; bus.hue_load = 1'b1;
    @(negedge CLK);
    bus.hue_load = 1'b0;
    bus.en = 1'b0;
    check("load400_hue", bus.hue_out, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("en0_rgb", {bus.RGB_R, bus.RGB_G, bus.RGB_B}, 3'b111);
      check("en0_hue", bus.hue_out, 0);
      check("en0_ftick", bus.frame_tick, 0);
    end
    bus.en = 1'b1;

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      bus.hue_load = ($urandom_range(0, 15) == 0);
      if (bus.hue_load) bus.hue_in = 9'($urandom_range(0, 511));
      bus.en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) begin
        bus.mode     = 2'($urandom_range(0, 3));
        bus.step_div = 24'($urandom_range(0, 4));
        bus.bright   = 4'($urandom_range(0, 15));
      end
    end
    @(negedge CLK);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
